table_collector: RTL and testbench
==================================

# table_collector

Byte-to-table packer: accepts a stream of 16 bytes over a valid/ready handshake, writes them into a 4x4 byte table, and presents the full table as one 128-bit word. It is the write-side counterpart of the row/col byte-read table buffer. A 128-bit word produced here can be loaded directly into that buffer, and its bytes read back at the same row/col positions.

## Interface
- COL_MAJOR, default 0: fill order. 0 = row-major: index i goes to row=i[3:2], col=i[1:0]. 1 = column-major: row=i[1:0], col=i[3:2].
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous clear. Aborts the current fill and zeroes the table.
- in_valid  input  1  data_in holds a byte.
- in_ready  output  1  block can accept a byte this cycle.
- data_in  input  8  byte to store.
- row  output  2  row the next accepted byte will be written to.
- col  output  2  column the next accepted byte will be written to.
- count  output  5  number of bytes stored so far (0..16).
- out_valid  output  1  table is complete and data_out is valid.
- out_ready  input  1  consumer takes data_out.
- data_out  output  128  packed table. table[0][0] at bits [127:120], then table[0][1], and so on, with table[3][3] at bits [7:0] (row r, col c at bits [127-8*(4r+c) -: 8]).

## Operation
- Storage: 16 x 8-bit table plus a 4-bit write index idx.
- States: FILL and FULL.
- FILL:
  - in_ready=1, out_valid=0.
  - On in_valid & in_ready, data_in is written to table[row][col] and idx increments.
  - When the accepted byte is the one at idx=15, the next state is FULL and idx wraps to 0.
- FULL:
  - in_ready=0, out_valid=1. data_out and the table are frozen.
  - On out_valid & out_ready, the next state is FILL. idx is already 0. The table is NOT cleared; bytes are overwritten as the next fill proceeds.
- count:
  - equals idx in FILL;
  - equals 16 in FULL.
- row/col are decoded combinationally from idx according to COL_MAJOR.
- data_out is always the concatenation of the current table, in every state.
- clr has priority over every handshake:
  - next state is FILL, idx=0, all table bytes are 0;
  - a byte offered in the same cycle is dropped;
  - an out_ready in the same cycle has no further effect (the consumer must treat it as not transferred).
- in_valid while in FULL is ignored; the byte stays pending upstream.
- No combinational path from in_valid or out_ready to any output.

## Timing
- Reset values: state=FILL, idx=0, table all zero. Outputs: in_ready=1, out_valid=0, count=0, row=0, col=0, data_out=0.
- rst asserted mid-fill or in FULL: immediate return to the reset values, with no clock edge needed.
- Write latency: a byte accepted at edge k is visible in data_out after edge k.
- out_valid rises on the edge that accepts the 16th byte.
- Minimum period per table is 17 cycles: 16 accept cycles plus 1 FULL cycle when out_ready is held at 1.
- out_valid stays high, with data_out stable, for as long as out_ready=0.

## Structure
- Shared package holds:
  - TABLE_DIM=4, BYTE_W=8, TABLE_W=128;
  - a state enum {FILL, FULL};
  - a function mapping (row, col) to a bit offset. The read-side buffer uses the same function so the packing order is defined in one place.
- One natural sub-module, table_index_gen. It holds the idx counter, wrap logic, and the COL_MAJOR row/col decode. The table storage and FSM stay in the top level.

## Test plan
- Reset, then stream bytes 0x00..0x0F with in_valid held high, COL_MAJOR=0, out_ready=0.
  - out_valid rises after the 16th edge and holds.
  - data_out=0x000102030405060708090A0B0C0D0E0F.
  - in_ready=0 and count=16 throughout FULL.
- COL_MAJOR=1, same stream.
  - data_out=0x0004080C0105090D02060A0E03070B0F.
  - row/col sequence starts (0,0),(1,0),(2,0).
- Random in_valid gaps, then out_ready pulsed 3 cycles after out_valid.
  - Exactly 16 bytes accepted; data is independent of gaps.
  - out_valid drops the cycle after the handshake; count=0 and in_ready=1.
- Back-to-back tables with out_ready held at 1.
  - A second stream of 0xF0..0xFF yields 0xF0F1..FF.
  - A 17-cycle period is measured.
- clr asserted after 7 bytes, with in_valid high in the same cycle.
  - count=0 and data_out=0 next cycle; the byte in the clr cycle is dropped.
  - The next 16 bytes form a complete table.
- Async rst asserted mid-cycle while in FULL.
  - Outputs return to the reset values immediately, before the next edge.

Source files
------------

// File: rtl/table_collector_pkg.sv
// Shared definitions for the 4x4 byte table writer and its read-side counterpart.
// cell_msb() fixes the packing order of the 128-bit table word in one place.
package table_collector_pkg;

    localparam int unsigned TABLE_DIM = 4;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned TABLE_W   = 128;

    typedef enum logic {
        FILL,
        FULL
    } state_e;

    // MSB bit position of table[row][col]; table[0][0] sits in the top byte.
    function automatic logic [6:0] cell_msb(input logic [1:0] row, input logic [1:0] col);
        return 7'(TABLE_W - 1 - BYTE_W * (TABLE_DIM * int'(row) + int'(col)));
    endfunction

endpackage

// File: rtl/table_index_gen.sv
// Write index counter for the table collector: 4-bit idx with natural wrap,
// plus the row/col decode selected by COL_MAJOR.
module table_index_gen
    import table_collector_pkg::*;
#(
    parameter bit COL_MAJOR = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       advance,
    output logic [3:0] idx,
    output logic [1:0] row,
    output logic [1:0] col,
    output logic       last
);

    logic [3:0] idx_d, idx_q;

    always_comb begin
        idx_d = idx_q;
        if (clr) begin
            idx_d = 4'd0;
        end else if (advance) begin
            // 15 + 1 wraps to 0, so idx is already 0 when the table goes FULL
            idx_d = idx_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= 4'd0;
        end else begin
            idx_q <= idx_d;
        end
    end

    always_comb begin
        if (COL_MAJOR) begin
            row = idx_q[1:0];
            col = idx_q[3:2];
        end else begin
            row = idx_q[3:2];
            col = idx_q[1:0];
        end
    end

    assign idx  = idx_q;
    assign last = (idx_q == 4'd15);

endmodule

// File: rtl/table_collector.sv
// Byte-to-table packer: collects 16 bytes into a 4x4 table and hands the whole
// table out as one 128-bit word over a valid/ready handshake.
module table_collector
    import table_collector_pkg::*;
#(
    parameter bit COL_MAJOR = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   data_in,
    output logic [1:0]   row,
    output logic [1:0]   col,
    output logic [4:0]   count,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out
);

    localparam int unsigned Cells = TABLE_DIM * TABLE_DIM;

    state_e            state_d, state_q;
    logic [BYTE_W-1:0] table_d [Cells];
    logic [BYTE_W-1:0] table_q [Cells];
    logic [3:0]        idx;
    logic              last;
    logic              accept;

    assign in_ready  = (state_q == FILL);
    assign out_valid = (state_q == FULL);
    assign accept    = in_ready && in_valid;
    assign count     = out_valid ? 5'd16 : {1'b0, idx};

    table_index_gen #(
        .COL_MAJOR(COL_MAJOR)
    ) u_index_gen (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .advance(accept && !clr),
        .idx    (idx),
        .row    (row),
        .col    (col),
        .last   (last)
    );

    always_comb begin
        state_d = state_q;
        table_d = table_q;
        if (clr) begin
            state_d = FILL;
            for (int i = 0; i < Cells; i++) begin
                table_d[i] = '0;
            end
        end else begin
            unique case (state_q)
                FILL: begin
                    if (accept) begin
                        table_d[{row, col}] = data_in;
                        if (last) begin
                            state_d = FULL;
                        end
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        state_d = FILL;
                    end
                end
                default: state_d = FILL;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            for (int i = 0; i < Cells; i++) begin
                table_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            table_q <= table_d;
        end
    end

    always_comb begin
        data_out = '0;
        for (int i = 0; i < Cells; i++) begin
            data_out[cell_msb(2'(i / 4), 2'(i % 4)) -: BYTE_W] = table_q[i];
        end
    end

endmodule

// File: tb/tb_table_collector.sv
// Randomised bench for table_collector: two instances (row- and column-major)
// share stimulus and are compared every cycle against a behavioural table model.
module tb_table_collector;

    logic         clk;
    logic         rst;
    logic         clr;
    logic         in_valid;
    logic         out_ready;
    logic [7:0]   data_in;
    logic         in_ready_w  [2];
    logic [1:0]   row_w       [2];
    logic [1:0]   col_w       [2];
    logic [4:0]   count_w     [2];
    logic         out_valid_w [2];
    logic [127:0] data_out_w  [2];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit chk_en   = 0;

    // Model: bytes stored so far, a full flag and the table by (row*4 + col)
    logic [7:0] mtab  [2][16];
    int         mn    [2];
    bit         mfull [2];

    table_collector #(.COL_MAJOR(1'b0)) dut0 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_w[0]),
        .data_in(data_in), .row(row_w[0]), .col(col_w[0]), .count(count_w[0]),
        .out_valid(out_valid_w[0]), .out_ready(out_ready), .data_out(data_out_w[0])
    );

    table_collector #(.COL_MAJOR(1'b1)) dut1 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_w[1]),
        .data_in(data_in), .row(row_w[1]), .col(col_w[1]), .count(count_w[1]),
        .out_valid(out_valid_w[1]), .out_ready(out_ready), .data_out(data_out_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int exp_row(input int m, input int n);
        return (m == 1) ? (n % 16) % 4 : (n % 16) / 4;
    endfunction

    function automatic int exp_col(input int m, input int n);
        return (m == 1) ? (n % 16) / 4 : (n % 16) % 4;
    endfunction

    function automatic logic [127:0] exp_data(input int m);
        logic [127:0] w;
        w = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                w[127 - 8 * (4 * r + c) -: 8] = mtab[m][4 * r + c];
        return w;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        for (int m = 0; m < 2; m++) begin
            if (rst || clr) begin
                for (int i = 0; i < 16; i++) mtab[m][i] <= 8'h00;
                mn[m]    <= 0;
                mfull[m] <= 1'b0;
            end else if (!mfull[m] && in_valid) begin
                mtab[m][4 * exp_row(m, mn[m]) + exp_col(m, mn[m])] <= data_in;
                mn[m]    <= mn[m] + 1;
                mfull[m] <= (mn[m] == 15);
            end else if (mfull[m] && out_ready) begin
                mn[m]    <= 0;
                mfull[m] <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && chk_en) begin
            for (int m = 0; m < 2; m++) begin
                check("in_ready", 128'(in_ready_w[m]), 128'(!mfull[m]));
                check("out_valid", 128'(out_valid_w[m]), 128'(mfull[m]));
                check("count", 128'(count_w[m]), 128'(mfull[m] ? 16 : mn[m]));
                check("row", 128'(row_w[m]), 128'(exp_row(m, mn[m])));
                check("col", 128'(col_w[m]), 128'(exp_col(m, mn[m])));
                check("data_out", data_out_w[m], exp_data(m));
            end
        end
    end

    initial begin
        int  k;
        int  guard;
        int  rises;
        int  t_rise [2];
        bit  prev;
        bit  acc;

        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; data_in = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        check("reset_count", 128'(count_w[0]), 128'd0);
        check("reset_in_ready", 128'(in_ready_w[0]), 128'd1);
        check("reset_out_valid", 128'(out_valid_w[1]), 128'd0);
        check("reset_data", data_out_w[0], 128'd0);

        // Straight stream 0x00..0x0F, consumer stalled
        for (int i = 0; i < 16; i++) begin
            if (i < 3) begin
                check("cm_row_seq", 128'(row_w[1]), 128'(i));
                check("cm_col_seq", 128'(col_w[1]), 128'd0);
            end
            in_valid = 1'b1;
            data_in  = 8'(i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (3) begin
            check("full_out_valid", 128'(out_valid_w[0]), 128'd1);
            check("full_in_ready", 128'(in_ready_w[0]), 128'd0);
            check("full_count", 128'(count_w[1]), 128'd16);
            check("rm_data", data_out_w[0], 128'h000102030405060708090A0B0C0D0E0F);
            check("cm_data", data_out_w[1], 128'h0004080C0105090D02060A0E03070B0F);
            in_valid = 1'b1;
            data_in  = 8'h55;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("release_out_valid", 128'(out_valid_w[0]), 128'd0);

        // Random gaps; count only handshakes the bench itself issued
        k = 0;
        guard = 0;
        while (k < 16 && guard < 400) begin
            guard++;
            in_valid = 1'($urandom_range(0, 1));
            data_in  = 8'($urandom);
            acc = in_valid && in_ready_w[0];
            @(negedge clk);
            if (acc) k++;
        end
        in_valid = 1'b0;
        check("gap_accepted", 128'(k), 128'd16);
        check("gap_full", 128'(out_valid_w[0]), 128'd1);
        repeat (3) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("gap_drop_valid", 128'(out_valid_w[1]), 128'd0);
        check("gap_drop_count", 128'(count_w[0]), 128'd0);
        check("gap_drop_ready", 128'(in_ready_w[0]), 128'd1);

        // Back-to-back tables with the consumer always ready
        out_ready = 1'b1;
        k = 0;
        guard = 0;
        rises = 0;
        prev = 1'b0;
        t_rise[0] = 0;
        t_rise[1] = 0;
        while (rises < 2 && guard < 100) begin
            guard++;
            if (out_valid_w[0] && !prev) begin
                t_rise[rises] = cyc;
                if (rises == 0)
                    check("b2b_data", data_out_w[0], 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF);
                rises++;
            end
            prev = out_valid_w[0];
            if (rises < 2) begin
                in_valid = 1'b1;
                data_in  = 8'hF0 | 8'(k % 16);
                acc = in_ready_w[0];
                @(negedge clk);
                if (acc) k++;
            end
        end
        check("b2b_rises", 128'(rises), 128'd2);
        check("b2b_period", 128'(t_rise[1] - t_rise[0]), 128'd17);
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;

        // clr after 7 bytes, with a byte offered in the clr cycle
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            data_in  = 8'($urandom);
            @(negedge clk);
        end
        clr = 1'b1;
        data_in = 8'hAA;
        @(negedge clk);
        clr = 1'b0;
        in_valid = 1'b0;
        check("clr_count", 128'(count_w[0]), 128'd0);
        check("clr_data", data_out_w[1], 128'd0);
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            data_in  = 8'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("clr_refill_full", 128'(out_valid_w[0]), 128'd1);
        check("clr_refill_count", 128'(count_w[1]), 128'd16);

        // Asynchronous reset in the middle of a FULL cycle
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        for (int m = 0; m < 2; m++) begin
            check("arst_out_valid", 128'(out_valid_w[m]), 128'd0);
            check("arst_in_ready", 128'(in_ready_w[m]), 128'd1);
            check("arst_count", 128'(count_w[m]), 128'd0);
            check("arst_rowcol", 128'({row_w[m], col_w[m]}), 128'd0);
            check("arst_data", data_out_w[m], 128'd0);
        end
        #1;
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
